// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the write-back arbiter and its per-source FIFOs.
package wb_arbiter_pkg;

    localparam int unsigned NR_WB_SRC     = 3;
    localparam int unsigned NR_WB_PORTS   = 2;
    localparam int unsigned WB_FIFO_DEPTH = 4;
    localparam int unsigned TRANS_ID_BITS = 8;
    localparam int unsigned XLEN          = 32;

    typedef logic [$clog2(NR_WB_SRC)-1:0] wb_src_idx_t;

    // Source slot assignment on the arbiter input side
    localparam wb_src_idx_t WB_SRC_ALU  = wb_src_idx_t'(0);
    localparam wb_src_idx_t WB_SRC_NONE = wb_src_idx_t'(1);
    localparam wb_src_idx_t WB_SRC_LSU  = wb_src_idx_t'(2);

    typedef struct packed {
        logic [TRANS_ID_BITS-1:0] id;
        logic [XLEN-1:0]          result;
    } fu_output_t;

    typedef struct packed {
        logic [TRANS_ID_BITS-1:0] id;
        logic                     valid;
    } completion_port_t;

endpackage

// File: rtl/wb_fifo.sv
// Single-source result FIFO. The caller must not push when full or pop when empty.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = WB_FIFO_DEPTH,
    parameter type         T     = fu_output_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  T                         data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output T                         head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    T               mem [DEPTH];
    logic [AW-1:0]  wr_q;
    logic [AW-1:0]  rd_q;
    logic [CW-1:0]  count_q;

    // Storage and pointer update; flush behaves exactly like reset
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem[wr_q] <= data;
                wr_q      <= wr_q + AW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + AW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (!push && pop) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem[rd_q];

endmodule

// File: rtl/wb_arbiter.sv
// Buffers per-FU results and arbitrates them round-robin onto the write-back ports.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned NR_SRC   = NR_WB_SRC,
    parameter int unsigned NR_PORTS = NR_WB_PORTS,
    parameter int unsigned DEPTH    = WB_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  fu_output_t            src_i [NR_SRC],
    input  logic [NR_SRC-1:0]     src_i_valid,
    output logic [NR_SRC-1:0]     src_i_ready,
    output fu_output_t            wb_o [NR_PORTS],
    output logic [NR_PORTS-1:0]   wb_o_valid,
    output completion_port_t      compl_o [NR_PORTS]
);

    localparam int unsigned IDX_W = (NR_SRC > 1) ? $clog2(NR_SRC) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [IDX_W-1:0]  rr_q;
    logic [IDX_W-1:0]  rr_d;
    logic [NR_SRC-1:0] push;
    logic [NR_SRC-1:0] pop;
    logic [NR_SRC-1:0] full;
    logic [NR_SRC-1:0] empty;
    fu_output_t        head  [NR_SRC];
    logic [CNT_W-1:0]  count [NR_SRC];

    int unsigned       pos  [NR_SRC];
    int unsigned       rank [NR_SRC];
    int unsigned       last_pos;
    logic              any_gnt;

    // Ready depends on registered occupancy only, so a full FIFO stays not-ready during its pop cycle
    assign src_i_ready = ~full;
    assign push        = src_i_valid & src_i_ready;

    for (genvar s = 0; s < NR_SRC; s++) begin : g_src
        wb_fifo #(
            .DEPTH (DEPTH),
            .T     (fu_output_t)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .flush (flush_i),
            .push  (push[s]),
            .pop   (pop[s]),
            .data  (src_i[s]),
            .full  (full[s]),
            .empty (empty[s]),
            .count (count[s]),
            .head  (head[s])
        );

        // Occupancy can never exceed the FIFO depth
        always_ff @(posedge clk) begin
            if (!rst) assert (count[s] <= CNT_W'(DEPTH));
        end
    end

    // Rank each non-empty source by its distance from rr_q; rank r goes to port r.
    // Comparing ranks avoids variable-indexed port selection.
    always_comb begin
        for (int unsigned s = 0; s < NR_SRC; s++) begin
            pos[s] = (s + NR_SRC - 32'(rr_q)) % NR_SRC;
        end
        for (int unsigned s = 0; s < NR_SRC; s++) begin
            rank[s] = 0;
            for (int unsigned t = 0; t < NR_SRC; t++) begin
                if (!empty[t] && (pos[t] < pos[s])) begin
                    rank[s] = rank[s] + 1;
                end
            end
        end
        pop      = '0;
        any_gnt  = 1'b0;
        last_pos = 0;
        for (int unsigned s = 0; s < NR_SRC; s++) begin
            if (!empty[s] && (rank[s] < NR_PORTS)) begin
                pop[s]  = 1'b1;
                any_gnt = 1'b1;
                if (pos[s] > last_pos) begin
                    last_pos = pos[s];
                end
            end
        end
        rr_d = any_gnt ? IDX_W'((32'(rr_q) + last_pos + 1) % NR_SRC) : rr_q;
    end

    // Drive each port from the source holding its rank; completion mirrors write-back
    always_comb begin
        for (int unsigned p = 0; p < NR_PORTS; p++) begin
            wb_o[p]       = '0;
            wb_o_valid[p] = 1'b0;
            for (int unsigned s = 0; s < NR_SRC; s++) begin
                if (pop[s] && (rank[s] == p)) begin
                    wb_o[p]       = head[s];
                    wb_o_valid[p] = 1'b1;
                end
            end
            compl_o[p].id    = wb_o[p].id;
            compl_o[p].valid = wb_o_valid[p];
        end
    end

    // Round-robin pointer moves past the last granted source, holds when idle
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule
